fp_mul_serial_param: RTL
========================

# fp_mul_serial_param

Parametrised successor to the byte-serial IEEE 754 double multiplier. It accepts two floating-point operands as little-endian IO_W-bit beats, multiplies their significands with a one-bit-per-cycle shift-add datapath, and rounds under a selectable rounding mode. It returns the product as little-endian beats together with IEEE exception flags. Subnormal inputs are treated as zero (DAZ) and subnormal results are flushed to zero (FTZ). It sits in the same accelerator slot as the fixed-format multiplier and also serves single/half precision.

## Interface
- EXP_W, 11, exponent width; BIAS = 2^(EXP_W-1)-1
- FRAC_W, 52, stored fraction width; MAN_W = FRAC_W+1
- IO_W, 8, beat width; W = 1+EXP_W+FRAC_W must be a multiple of IO_W; NBEAT = W/IO_W
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- ENABLE  in  1  DATA_IN holds a valid operand beat this cycle
- DATA_IN  in  IO_W  operand beat, least-significant beat first
- RM  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (toward +inf), 3 RDN (toward -inf); sampled with the first beat of A
- BUSY  out  1  high outside LOAD_A/LOAD_B; ENABLE is ignored while high
- DATA_OUT  out  IO_W  result beat, least-significant beat first
- READY  out  1  DATA_OUT valid
- FLAGS  out  5  {NV, OF, UF, IX, DN}; valid while READY is high

## Operation
- States: LOAD_A -> LOAD_B -> CLASS -> (MUL -> NORM -> ROUND | special) -> OUT -> LOAD_A.
- LOAD_A/LOAD_B: beat counter advances only on ENABLE=1. ENABLE=0 stalls without losing any beat. The NBEAT-th beat moves the block to the next state.
- CLASS: decode sign, exponent and fraction of both operands.
  - A zero-exponent operand with a nonzero fraction counts as zero and sets DN.
  - The special cases below load the result and go straight to OUT.
- Special cases, in priority order:
  - Either operand NaN: result is the canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0). NV is set if either NaN is signalling (fraction MSB 0).
  - inf × 0: canonical qNaN, NV set.
  - inf × nonzero: inf with sign = sA^sB.
  - 0 × finite: zero with sign = sA^sB.
- MUL: MAN_W cycles. Cycle i adds {1,fracA}<<i into a 2*MAN_W-bit accumulator when bit i of {1,fracB} is 1.
- NORM:
  - If product MSB = 1, keep the product and add 1 to the exponent; otherwise shift left 1.
  - Exponent: e = eA+eB-BIAS+adj, computed as an (EXP_W+2)-bit signed value.
  - Guard = the bit below the kept MAN_W bits; sticky = OR of all lower bits.
- ROUND: increment decision by mode.
  - RNE: G&(S|LSB).
  - RTZ: never.
  - RUP: (G|S)&~sign.
  - RDN: (G|S)&sign.
  - IX = G|S.
  - A significand carry-out increments the exponent.
- Overflow (e ≥ 2^EXP_W-1 after rounding): set OF|IX.
  - Result is inf for RNE, for RUP when positive, and for RDN when negative.
  - Otherwise the result is the maximum finite value with that sign.
- Underflow (e ≤ 0): result is signed zero, UF|IX set.
- OUT: NBEAT cycles with READY=1; beat k = result[k*IO_W +: IO_W]. Then return to LOAD_A with all internal registers cleared.
- Reset: takes effect immediately at any point, including mid-load or mid-MUL.
  - State returns to LOAD_A and the beat counter clears.
  - DATA_OUT=0, READY=0, FLAGS=0, BUSY=0.
  - The partial transaction is discarded.

## Timing
- t0 = the rising edge that captures the last beat of B; BUSY rises at t0.
- Special case: READY rises at t0+2.
- Normal case: READY rises at t0+MAN_W+4. Defaults give t0+57; EXP_W=8, FRAC_W=23 gives t0+28.
- READY stays high exactly NBEAT cycles; it and BUSY fall on the same edge.
- The first A beat may arrive in the cycle right after READY falls.
- DATA_OUT holds its last value while READY=0.
- All outputs are registered.

## Test plan
- Defaults, RNE: A=0x3FF8000000000000, B=0x4000000000000000 -> 0x4008000000000000, FLAGS=0, READY at t0+57. With EXP_W=8, FRAC_W=23: 0x3FC00000 × 0x40000000 -> 0x40400000, READY at t0+28.
- 0x7FF0000000000000 × 0x0000000000000000 -> 0x7FF8000000000000, NV=1, READY at t0+2. 0xFFF0000000000000 × 0x4000000000000000 -> 0xFFF0000000000000, FLAGS=0.
- A=B=0x3FF0000000000001 -> RNE 0x3FF0000000000002 IX=1; RUP 0x3FF0000000000003 IX=1; RTZ 0x3FF0000000000002.
- 0x7FEFFFFFFFFFFFFF × 0x4000000000000000 -> RNE 0x7FF0000000000000 OF|IX; RTZ 0x7FEFFFFFFFFFFFFF OF|IX.
- 0x8010000000000000 × 0x3FE0000000000000 -> 0x8000000000000000 UF|IX. 0x0000000000000001 × 0x4000000000000000 -> 0x0000000000000000 DN=1.
- ENABLE low for 3 cycles mid-B -> same result, timed from the delayed t0. RESET_N low during MUL -> READY/BUSY drop immediately; the next full transaction returns correct results.

Source files
------------

// File: rtl/fp_mul_serial_param.sv
// Beat-serial IEEE 754 multiplier: one significand bit per cycle, selectable
// rounding, subnormal inputs treated as zero and subnormal results flushed.
module fp_mul_serial_param #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int IO_W   = 8
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic [IO_W-1:0] DATA_IN,
  input  logic [1:0]      RM,
  output logic            BUSY,
  output logic [IO_W-1:0] DATA_OUT,
  output logic            READY,
  output logic [4:0]      FLAGS
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int MAN_W = FRAC_W + 1;
  localparam int NBEAT = W / IO_W;
  localparam int PW    = 2 * MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam int CW_M  = $clog2(MAN_W + 1);
  localparam int CW_B  = $clog2(NBEAT + 1);
  localparam int CW    = (CW_M > CW_B) ? CW_M : CW_B;

  localparam logic signed [EW-1:0] BIAS_S = EW'((2**(EXP_W-1)) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'((2**EXP_W) - 1);

  localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [W-2:0]   INF_M = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  localparam logic [W-2:0]   MAX_M = {{(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_CLASS  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_a, r_b, r_res;
  logic [1:0]           r_rm;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [PW-1:0]        r_acc, r_ma;
  logic [MAN_W-1:0]     r_mb;
  logic [FRAC_W-1:0]    r_frac;
  logic                 r_g, r_s;
  logic [4:0]           r_flags;
  logic                 r_busy, r_ready;
  logic [IO_W-1:0]      r_dout;

  logic [W-1:0]         w_in_hi;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [FRAC_W-1:0]    w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic                 w_sign, w_dn, w_nv;
  logic                 w_hi;
  logic [FRAC_W-1:0]    w_kept;
  logic                 w_guard, w_sticky;
  logic                 w_inc, w_inexact, w_ovf, w_unf, w_to_inf;
  logic [FRAC_W:0]      w_man_r;
  logic signed [EW-1:0] w_exp_r;
  logic [W-1:0]         w_round_res;

  assign w_in_hi = W'(DATA_IN) << (W - IO_W);

  assign w_ea     = r_a[W-2:FRAC_W];
  assign w_eb     = r_b[W-2:FRAC_W];
  assign w_fa     = r_a[FRAC_W-1:0];
  assign w_fb     = r_b[FRAC_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_sign   = r_a[W-1] ^ r_b[W-1];
  assign w_dn     = (w_a_zero & (|w_fa)) | (w_b_zero & (|w_fb));
  assign w_nv     = (w_a_nan & ~w_fa[FRAC_W-1]) | (w_b_nan & ~w_fb[FRAC_W-1]) |
                    (~(w_a_nan | w_b_nan) & ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)));

  // Kept significand's leading 1 is implicit, so only the fraction is stored.
  assign w_hi     = r_acc[PW-1];
  assign w_kept   = w_hi ? r_acc[PW-2 -: FRAC_W] : r_acc[PW-3 -: FRAC_W];
  assign w_guard  = w_hi ? r_acc[MAN_W-1] : r_acc[MAN_W-2];
  assign w_sticky = w_hi ? (|r_acc[MAN_W-2:0]) : (|r_acc[MAN_W-3:0]);

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      2'd0:    w_inc = r_g & (r_s | r_frac[0]);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = (r_g | r_s) & ~r_sign;
      default: w_inc = (r_g | r_s) & r_sign;
    endcase
  end

  assign w_inexact = r_g | r_s;
  assign w_man_r   = {1'b0, r_frac} + (FRAC_W+1)'(w_inc);
  assign w_exp_r   = r_exp + $signed({{(EW-1){1'b0}}, w_man_r[FRAC_W]});
  assign w_ovf     = ~w_exp_r[EW-1] & (w_exp_r >= EMAX_S);
  assign w_unf     = w_exp_r[EW-1] | (w_exp_r == '0);
  assign w_to_inf  = (r_rm == 2'd0) | ((r_rm == 2'd2) & ~r_sign) | ((r_rm == 2'd3) & r_sign);

  always_comb begin
    w_round_res = {r_sign, w_exp_r[EXP_W-1:0], w_man_r[FRAC_W-1:0]};
    if (w_ovf)
      w_round_res = {r_sign, (w_to_inf ? INF_M : MAX_M)};
    else if (w_unf)
      w_round_res = {r_sign, {(W-1){1'b0}}};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_LOAD_A;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_rm    <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_acc   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_frac  <= '0;
      r_g     <= 1'b0;
      r_s     <= 1'b0;
      r_flags <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_LOAD_A: if (ENABLE) begin
          r_a <= (r_a >> IO_W) | w_in_hi;
          if (r_cnt == '0) r_rm <= RM;
          if (r_cnt == CW'(NBEAT-1)) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_B;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD_B: if (ENABLE) begin
          r_b <= (r_b >> IO_W) | w_in_hi;
          if (r_cnt == CW'(NBEAT-1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CLASS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CLASS: begin
          r_sign  <= w_sign;
          r_flags <= {w_nv, 3'b000, w_dn};
          r_state <= S_OUT;
          if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
            r_res <= QNAN;
          else if (w_a_inf | w_b_inf)
            r_res <= {w_sign, INF_M};
          else if (w_a_zero | w_b_zero)
            r_res <= {w_sign, {(W-1){1'b0}}};
          else begin
            r_exp   <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;
            r_acc   <= '0;
            r_ma    <= PW'({1'b1, w_fa});
            r_mb    <= {1'b1, w_fb};
            r_cnt   <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mb[0]) r_acc <= r_acc + r_ma;
          r_ma <= r_ma << 1;
          r_mb <= r_mb >> 1;
          if (r_cnt == CW'(MAN_W-1)) begin
            r_cnt   <= '0;
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NORM: begin
          r_frac  <= w_kept;
          r_g     <= w_guard;
          r_s     <= w_sticky;
          r_exp   <= r_exp + $signed({{(EW-1){1'b0}}, w_hi});
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_res   <= w_round_res;
          r_flags <= {1'b0, w_ovf, w_unf & ~w_ovf, w_inexact | w_ovf | w_unf, r_flags[0]};
          r_state <= S_OUT;
        end
        S_OUT: begin
          // First OUT cycle only primes the beat shifter; READY follows one edge later.
          if (!r_ready) begin
            r_ready <= 1'b1;
            r_dout  <= r_res[IO_W-1:0];
            r_res   <= r_res >> IO_W;
            r_cnt   <= CW'(1);
          end else if (r_cnt == CW'(NBEAT)) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_LOAD_A;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_rm    <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_acc   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_frac  <= '0;
            r_g     <= 1'b0;
            r_s     <= 1'b0;
          end else begin
            r_dout <= r_res[IO_W-1:0];
            r_res  <= r_res >> IO_W;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign READY    = r_ready;
  assign DATA_OUT = r_dout;
  assign FLAGS    = r_flags;

endmodule
